// File: rtl/vga_timing_controller.sv
// VGA raster timing generator with a small built-in test-pattern source.
// Counters advance on every enabled clock; all outputs are registered one cycle behind.
module vga_timing_controller #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [1:0] PATTERN_SEL,
  output logic       HS,
  output logic       VS,
  output logic       DE,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       FRAME_START,
  output logic       LINE_START,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_END = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE_END = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_BARS  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_GRAD  = 2'd3
  } pat_e;

  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  pat_e          pat, pat_cur;
  logic          at_origin, de_c, hs_c, vs_c;
  logic [9:0]    xc, yc, bar;
  logic [11:0]   rgb_c;

  always_comb begin
    h_nxt = h + HW'(1);
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + VW'(1);
    end

    at_origin = (h == '0) && (v == '0);
    // The origin pixel already uses the newly sampled pattern, since that is the latch point.
    pat_cur = at_origin ? pat_e'(PATTERN_SEL) : pat;

    de_c = (h < H_DE_END) && (v < V_DE_END);
    hs_c = (h >= HS_BEG) && (h < HS_END);
    vs_c = (v >= VS_BEG) && (v < VS_END);
    xc   = 10'(h);
    yc   = 10'(v);
    bar  = xc / 10'd100;

    rgb_c = '0;
    case (pat_cur)
      PAT_BARS: begin
        if (bar < 10'd8) begin
          case (bar[2:0])
            3'd0:    rgb_c = 12'hFFF;
            3'd1:    rgb_c = 12'hFF0;
            3'd2:    rgb_c = 12'h0FF;
            3'd3:    rgb_c = 12'h0F0;
            3'd4:    rgb_c = 12'hF0F;
            3'd5:    rgb_c = 12'hF00;
            3'd6:    rgb_c = 12'h00F;
            default: rgb_c = 12'h000;
          endcase
        end
      end
      PAT_CHECK: rgb_c = (xc[5] ^ yc[5]) ? 12'hFFF : 12'h000;
      PAT_GRAD:  rgb_c = {xc[7:4], yc[7:4], 4'h0};
      default:   rgb_c = '0;
    endcase
    if (!de_c) rgb_c = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h           <= '0;
      v           <= '0;
      pat         <= PAT_BLACK;
      HS          <= 1'b0;
      VS          <= 1'b0;
      DE          <= 1'b0;
      FRAME_START <= 1'b0;
      LINE_START  <= 1'b0;
      X           <= '0;
      Y           <= '0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else if (!ENABLE) begin
      h           <= '0;
      v           <= '0;
      HS          <= 1'b0;
      VS          <= 1'b0;
      DE          <= 1'b0;
      FRAME_START <= 1'b0;
      LINE_START  <= 1'b0;
      X           <= '0;
      Y           <= '0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else begin
      h           <= h_nxt;
      v           <= v_nxt;
      if (at_origin) pat <= pat_cur;
      HS          <= hs_c;
      VS          <= vs_c;
      DE          <= de_c;
      FRAME_START <= at_origin;
      LINE_START  <= (h == '0);
      X           <= xc;
      Y           <= yc;
      R           <= rgb_c[11:8];
      G           <= rgb_c[7:4];
      B           <= rgb_c[3:0];
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a default-timing instance for line/pattern checks and
// a reduced-timing instance so whole frames fit in a short run.
`timescale 1ns/100ps
module tb_vga_timing_controller;

  logic CLK = 1'b0;
  always #12.5 CLK = ~CLK;

  logic       RESET_N;
  logic       a_en, b_en;
  logic [1:0] a_ps, b_ps;
  logic       a_hs, a_vs, a_de, a_fs, a_ls;
  logic       b_hs, b_vs, b_de, b_fs, b_ls;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

  vga_timing_controller u_a (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(a_en), .PATTERN_SEL(a_ps),
    .HS(a_hs), .VS(a_vs), .DE(a_de), .X(a_x), .Y(a_y),
    .FRAME_START(a_fs), .LINE_START(a_ls), .R(a_r), .G(a_g), .B(a_b)
  );

  // 80 x 48 total raster: 64x40 visible, VS on lines 41..44
  vga_timing_controller #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(40), .V_FRONT(1), .V_SYNC(4), .V_BACK(3)
  ) u_b (
    .CLK(CLK), .RESET_N(RESET_N), .ENABLE(b_en), .PATTERN_SEL(b_ps),
    .HS(b_hs), .VS(b_vs), .DE(b_de), .X(b_x), .Y(b_y),
    .FRAME_START(b_fs), .LINE_START(b_ls), .R(b_r), .G(b_g), .B(b_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    bit          which;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        de;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_px(input string tag, input bit which, input logic [9:0] x,
                           input logic [9:0] y, input logic [11:0] rgb, input logic de);
    exp_t e;
    e.tag = tag; e.which = which; e.x = x; e.y = y; e.rgb = rgb; e.de = de;
    sbq.push_back(e);
  endtask

  // Pixel scoreboard: pops the head entry when its instance shows that position.
  always @(negedge CLK) begin
    if (sbq.size() != 0) begin
      exp_t        e;
      logic [9:0]  ox, oy;
      logic        ols, ode;
      logic [11:0] orgb;
      e = sbq[0];
      if (!e.which) begin
        ox = a_x; oy = a_y; ols = a_ls; ode = a_de; orgb = {a_r, a_g, a_b};
      end else begin
        ox = b_x; oy = b_y; ols = b_ls; ode = b_de; orgb = {b_r, b_g, b_b};
      end
      if (ox == e.x && oy == e.y && (e.x != 10'd0 || ols)) begin
        void'(sbq.pop_front());
        chk({e.tag, "_rgb"}, 32'(orgb), 32'(e.rgb));
        chk({e.tag, "_de"}, 32'(ode), 32'(e.de));
      end
    end
  end

  initial begin
    int   n, per, dec, hsc, hsf, rises, vsc, vsl;
    logic prev;

    RESET_N = 1'b0; a_en = 1'b1; b_en = 1'b0; a_ps = 2'd0; b_ps = 2'd2;
    repeat (3) @(negedge CLK);
    chk("rst_flags", 32'({a_hs, a_vs, a_de, a_fs, a_ls}), 0);
    chk("rst_xy", 32'({a_x, a_y}), 0);
    chk("rst_rgb", 32'({a_r, a_g, a_b}), 0);

    RESET_N = 1'b1; b_en = 1'b1;
    @(posedge CLK); #1;
    chk("first_fs", 32'(a_fs), 1);
    chk("first_ls", 32'(a_ls), 1);
    chk("first_xy", 32'({a_x, a_y}), 0);
    chk("first_de", 32'(a_de), 1);

    // One full line measured from its LINE_START cycle
    per = 0; dec = 0; hsc = 0; hsf = -1; rises = 0; prev = 1'b0;
    do begin
      if (a_de) dec++;
      if (a_hs) begin
        hsc++;
        if (!prev) begin
          rises++;
          if (hsf < 0) hsf = per;
        end
      end
      prev = a_hs;
      per++;
      @(posedge CLK); #1;
    end while (!a_ls && per < 3000);
    chk("line_period", per, 1056);
    chk("line_de", dec, 800);
    chk("line_hs_cnt", hsc, 128);
    chk("line_hs_start", hsf, 840);
    chk("line_hs_runs", rises, 1);
    chk("line2_y", 32'(a_y), 1);

    // Enable gap mid-line, with a new pattern requested during the gap
    repeat (500) @(posedge CLK);
    #1;
    a_ps = 2'd1; a_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk("gap_flags", 32'({a_hs, a_vs, a_de, a_fs, a_ls}), 0);
      chk("gap_xy", 32'({a_x, a_y}), 0);
      chk("gap_rgb", 32'({a_r, a_g, a_b}), 0);
    end
    expect_px("bar_x0",     1'b0, 10'd0,   10'd0, 12'hFFF, 1'b1);
    expect_px("bar_x150",   1'b0, 10'd150, 10'd0, 12'hFF0, 1'b1);
    expect_px("bar_x420",   1'b0, 10'd420, 10'd0, 12'hF0F, 1'b1);
    expect_px("bar_x750",   1'b0, 10'd750, 10'd0, 12'h000, 1'b1);
    expect_px("blank_x900", 1'b0, 10'd900, 10'd0, 12'h000, 1'b0);
    a_en = 1'b1;
    @(posedge CLK); #1;
    chk("reen_fs", 32'(a_fs), 1);
    chk("reen_xy", 32'({a_x, a_y}), 0);
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(posedge CLK); #1; n++;
    end
    chk("bars_drain", sbq.size(), 0);
    sbq.delete();

    // Full frame on the reduced instance
    n = 0;
    while (!b_fs && n < 5000) begin
      @(posedge CLK); #1; n++;
    end
    chk("b_fs_wait", 32'(b_fs), 1);
    per = 0; dec = 0; vsc = 0; vsl = -1;
    do begin
      if (b_de) dec++;
      if (b_vs) begin
        vsc++;
        if (vsl < 0) vsl = int'(b_y);
      end
      per++;
      @(posedge CLK); #1;
    end while (!b_fs && per < 10000);
    chk("frame_period", per, 3840);
    chk("frame_de", dec, 2560);
    chk("frame_vs_cnt", vsc, 320);
    chk("frame_vs_line", vsl, 41);

    // Pattern 2 -> 3 mid-frame: old pattern holds until the next frame
    n = 0;
    while (!(b_ls && b_y == 10'd35) && n < 5000) begin
      @(posedge CLK); #1; n++;
    end
    chk("b_y35_wait", 32'(b_y), 35);
    b_ps = 2'd3;
    expect_px("check_hold", 1'b1, 10'd32, 10'd37, 12'h000, 1'b1);
    expect_px("grad_next",  1'b1, 10'd53, 10'd33, 12'h320, 1'b1);
    n = 0;
    while (sbq.size() != 0 && n < 5000) begin
      @(posedge CLK); #1; n++;
    end
    chk("pat_drain", sbq.size(), 0);
    sbq.delete();

    // Asynchronous reset mid-frame abandons the frame
    repeat (37) @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("midrst_flags", 32'({a_hs, a_vs, a_de, a_fs, a_ls}), 0);
    chk("midrst_xy", 32'({a_x, a_y}), 0);
    chk("midrst_rgb", 32'({a_r, a_g, a_b}), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_fs", 32'(a_fs), 1);
    chk("midrst_xy0", 32'({a_x, a_y}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 800, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 40, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 128, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BACK, default 88, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, default 600, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 1, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 4, vertical sync width in lines.
REQ-008 SHALL have parameter V_BACK, default 23, vertical back porch in lines.
REQ-009 SHALL have port CLK, input, 1, 40 MHz pixel clock; single clock domain.
REQ-010 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port ENABLE, input, 1, run timing when high.
REQ-012 SHALL have port PATTERN_SEL, input, 2, requested test pattern.
REQ-013 SHALL have ports HS, VS and DE, output, 1 each: horizontal sync, vertical sync, data enable; sync outputs active-high.
REQ-014 SHALL have ports X and Y, output, 10 each, current pixel column and line.
REQ-015 SHALL have ports FRAME_START and LINE_START, output, 1 each, single-cycle pulses.
REQ-016 SHALL have ports R, G and B, output, 4 each, 12-bit pixel colour.

Function
REQ-017 SHALL keep horizontal counter h in 0..H_TOTAL-1 and vertical counter v in 0..V_TOTAL-1, where H_TOTAL is the sum of the four H_* parameters (1056 by default) and V_TOTAL is the sum of the four V_* parameters (628 by default).
REQ-018 SHALL increment h by 1 on every CLK with ENABLE high; on h=H_TOTAL-1, SHALL wrap h to 0 and increment v; on v=V_TOTAL-1 with that wrap, SHALL wrap v to 0.
REQ-019 SHALL register all outputs, one cycle latency from counter state: output cycle k after enable reflects position (k mod H_TOTAL, floor(k/H_TOTAL) mod V_TOTAL).
REQ-020 SHALL drive HS=1 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (840..967 by default).
REQ-021 SHALL drive VS=1 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (601..604 by default), for the whole of each such line.
REQ-022 SHALL drive DE=1 iff h<H_VISIBLE and v<V_VISIBLE; X=h and Y=v, truncated to 10 bits.
REQ-023 SHALL pulse LINE_START for the position h=0 (any v), and FRAME_START for h=0,v=0 only.
REQ-024 SHALL latch PATTERN_SEL into an internal pattern register only when the counters are at (0,0); a change mid-frame SHALL take effect at the next frame.
REQ-025 SHALL select colour by pattern register value:
- 0: black.
- 1: eight vertical bars, bar index = X/100, ordered white, yellow, cyan, green, magenta, red, blue, black; each channel is 0xF or 0x0.
- 2: checkerboard; white when X[5] XOR Y[5] is 1, else black.
- 3: gradient; R=X[7:4], G=Y[7:4], B=0.
REQ-026 SHALL force R=G=B=0 whenever DE=0.
REQ-027 SHALL, while ENABLE is low, synchronously clear h and v to 0 and drive HS, VS, DE, FRAME_START, LINE_START, X, Y, R, G and B to 0.
REQ-028 SHALL, when ENABLE rises, present position (0,0) with FRAME_START=1 on the first enabled output cycle.

Reset
REQ-029 SHALL, on RESET_N low, asynchronously clear h, v and the pattern register to 0, and drive all outputs to 0.
REQ-030 SHALL, after RESET_N deasserts, behave as in REQ-028 on the first CLK with ENABLE high; a reset asserted mid-frame SHALL abandon that frame.

Verification
REQ-031 SHALL verify: RESET_N=0 with ENABLE=1 -> all outputs 0; after release, FRAME_START=1 with X=0, Y=0 on the first enabled cycle.
REQ-032 SHALL verify: run one line -> DE high for 800 cycles, HS high for 128 consecutive cycles starting 840 cycles after LINE_START, LINE_START period 1056.
REQ-033 SHALL verify: run one frame -> FRAME_START period 663168 cycles, VS high for 4224 cycles starting at line 601, DE count 480000.
REQ-034 SHALL verify: PATTERN_SEL=1 -> at X=0 RGB=FFF, at X=150 RGB=FF0, at X=750 RGB=000; with DE=0, RGB=000.
REQ-035 SHALL verify: change PATTERN_SEL from 2 to 3 at line 300 -> pattern 2 holds until the next FRAME_START, then at X=0x35, Y=0x21 RGB=320.
REQ-036 SHALL verify: drop ENABLE mid-line for 5 cycles -> outputs 0 during the gap, then FRAME_START=1 at (0,0) on re-enable.
